// File: rtl/c_tile_drain.sv
// C-matrix read-out: queues result rows from the bottom PE row and serialises each tile to the host.
// Optional out_parity output when C_DRAIN_PARITY_EN is defined.
module c_tile_drain #(
  parameter int DATA_WIDTH = 16,
  parameter int WIDTH      = 4,
  parameter int HEIGHT     = 4,
  parameter int ROW_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        in_valid_C,
  input  logic [WIDTH*DATA_WIDTH-1:0] row_in,
  output logic                        row_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic                        tile_done,
`ifdef C_DRAIN_PARITY_EN
  output logic                        out_parity,
`endif
  output logic                        overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int PW = (ROW_DEPTH > 1) ? $clog2(ROW_DEPTH) : 1;
  localparam int NW = $clog2(ROW_DEPTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

  logic [1:0]                  r_state;
  logic [CW-1:0]               r_col;
  logic [RW-1:0]               r_row;
  logic [WIDTH*DATA_WIDTH-1:0] r_mem [ROW_DEPTH];
  logic [PW-1:0]               r_wptr;
  logic [PW-1:0]               r_rptr;
  logic [NW-1:0]               r_count;
  logic [DATA_WIDTH-1:0]       r_words [WIDTH];
  logic [DATA_WIDTH-1:0]       r_out_data;
  logic                        r_tile_done;
  logic                        r_overflow;

  logic                        w_push;
  logic                        w_pop;
  logic                        w_hs;
  logic                        w_col_last;
  logic                        w_row_last;
  logic                        w_nonempty;
  logic [CW-1:0]               w_next_col;
  logic [WIDTH*DATA_WIDTH-1:0] w_head;
  logic                        w_data_en;
  logic [DATA_WIDTH-1:0]       w_data_d;

  assign row_ready  = (r_count != NW'(ROW_DEPTH));
  assign w_nonempty = (r_count != '0);
  assign out_valid  = (r_state == S_SEND);
  assign w_hs       = out_valid & out_ready;
  assign w_col_last = (r_col == CW'(WIDTH - 1));
  assign w_row_last = (r_row == RW'(HEIGHT - 1));
  assign out_last   = out_valid & w_row_last & w_col_last;
  assign w_next_col = r_col + 1'b1;
  assign w_head     = r_mem[r_rptr];
  assign out_data   = r_out_data;
  assign tile_done  = r_tile_done;
  assign overflow   = r_overflow;

  // start overrides both sides of the FIFO; only LOAD ever pops, and it is entered only when non-empty
  assign w_push = in_valid_C & row_ready & ~start;
  assign w_pop  = (r_state == S_LOAD) & ~start;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= row_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (start) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == PW'(ROW_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      if (w_pop)  r_rptr <= (r_rptr == PW'(ROW_DEPTH - 1)) ? '0 : r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_data_en = 1'b0;
    w_data_d  = r_out_data;
    if (!start) begin
      if (r_state == S_LOAD) begin
        w_data_en = 1'b1;
        w_data_d  = w_head[0 +: DATA_WIDTH];
      end else if (w_hs && !w_col_last) begin
        w_data_en = 1'b1;
        w_data_d  = r_words[w_next_col];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_col   <= '0;
      r_row   <= '0;
      for (int unsigned c = 0; c < WIDTH; c++) r_words[c] <= '0;
    end else if (start) begin
      r_state <= S_IDLE;
      r_col   <= '0;
      r_row   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_nonempty) r_state <= S_LOAD;
        S_LOAD: begin
          for (int unsigned c = 0; c < WIDTH; c++)
            r_words[c] <= w_head[c*DATA_WIDTH +: DATA_WIDTH];
          r_col   <= '0;
          r_state <= S_SEND;
        end
        S_SEND: begin
          if (w_hs) begin
            if (w_col_last) begin
              r_col   <= '0;
              r_row   <= w_row_last ? '0 : r_row + 1'b1;
              r_state <= w_nonempty ? S_LOAD : S_IDLE;
            end else begin
              r_col <= w_next_col;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_tile_done <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_data_en) r_out_data <= w_data_d;
      r_tile_done <= ~start & w_hs & w_row_last & w_col_last;
      if (start)                         r_overflow <= 1'b0;
      else if (in_valid_C && !row_ready) r_overflow <= 1'b1;
    end
  end

`ifdef C_DRAIN_PARITY_EN
  logic r_parity;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_parity <= 1'b0;
    else if (w_data_en) r_parity <= ^w_data_d;
  end
  assign out_parity = r_parity;
`endif

endmodule

// File: tb/tb_c_tile_drain.sv
// Bench for c_tile_drain: word-level scoreboard plus directed latency/overflow/start scenarios.
module tb_c_tile_drain;
  localparam int DW = 16;
  localparam int W  = 4;
  localparam int TILE_WORDS = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid_C = 1'b0;
  logic [W*DW-1:0] row_in = '0;
  logic          row_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic          tile_done;
  logic          overflow;
`ifdef C_DRAIN_PARITY_EN
  logic          out_parity;
`endif

  always #5 clk = ~clk;

  c_tile_drain #(.DATA_WIDTH(DW), .WIDTH(W), .HEIGHT(4), .ROW_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid_C(in_valid_C), .row_in(row_in),
    .row_ready(row_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .tile_done(tile_done),
`ifdef C_DRAIN_PARITY_EN
    .out_parity(out_parity),
`endif
    .overflow(overflow)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: every accepted row contributes its words col0-first; every handshake consumes one;
  // the tile ends on each 16th handshake since the last start.
  logic [DW-1:0] exp_q[$];
  int            hs_cnt = 0;
  int            m_idx = 0;
  bit            exp_td = 1'b0;
  bit            hold_prev = 1'b0;
  logic [DW-1:0] hold_data = '0;
  logic [DW-1:0] last_data = '0;
  logic          last_last = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("tile_done", tile_done, exp_td);
      exp_td = 1'b0;
      if (hold_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, hold_data);
      end
      if (start) begin
        exp_q.delete();
        m_idx = 0;
        hold_prev = 1'b0;
      end else begin
        if (out_valid) begin
          chk("out_last", out_last, (m_idx % TILE_WORDS) == TILE_WORDS - 1);
`ifdef C_DRAIN_PARITY_EN
          chk("out_parity", out_parity, ^out_data);
          if (out_data == 16'h0007) chk("parity_0007", out_parity, 1);
          if (out_data == 16'h0003) chk("parity_0003", out_parity, 0);
`endif
          if (out_ready) begin
            if (exp_q.size() == 0) chk("spurious_word", out_valid, 0);
            else chk("out_data", out_data, exp_q.pop_front());
            last_data = out_data;
            last_last = out_last;
            exp_td = ((m_idx % TILE_WORDS) == TILE_WORDS - 1);
            m_idx++;
            hs_cnt++;
          end
        end else begin
          chk("out_last_idle", out_last, 0);
        end
        hold_prev = out_valid & ~out_ready;
        hold_data = out_data;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W*DW-1:0] r, input bit accept);
    in_valid_C = 1'b1;
    row_in = r;
    if (accept)
      for (int c = 0; c < W; c++) exp_q.push_back(r[c*DW +: DW]);
    tick;
    in_valid_C = 1'b0;
  endtask

  task automatic pulse_start;
    out_ready = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  function automatic logic [W*DW-1:0] mkrow(input int base);
    logic [W*DW-1:0] r;
    for (int c = 0; c < W; c++) r[c*DW +: DW] = DW'(base + c);
    return r;
  endfunction

  task automatic drain;
    for (int i = 0; i < 600; i++) begin
      if (exp_q.size() == 0) break;
      tick;
    end
    chk("drain_remaining", exp_q.size(), 0);
    repeat (2) tick;
  endtask

  int bub;
  int h0;
  logic [3:0] pat;

  initial begin
    // reset
    repeat (2) tick;
    chk("rst_row_ready", row_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_tile_done", tile_done, 0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    tick;

    // single tile, latency and inter-row bubbles
    out_ready = 1'b1;
    h0 = hs_cnt;
    push(mkrow(1), 1);
    chk("lat_t0_valid", out_valid, 0);
    push(mkrow(5), 1);
    chk("lat_t1_valid", out_valid, 0);
    push(mkrow(9), 1);
    chk("lat_t2_valid", out_valid, 1);
    chk("first_word", out_data, 16'h0001);
    push(mkrow(13), 1);
    bub = 0;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      if (!out_valid) bub++;
      tick;
    end
    chk("row_gaps", bub, 3);
    drain;
    chk("tile1_words", hs_cnt - h0, 16);
    chk("tile1_last_data", last_data, 16'h0010);
    chk("tile1_last_flag", last_last, 1);

    // backpressure pattern 1,0,0,1
    pulse_start;
    h0 = hs_cnt;
    for (int r = 0; r < 4; r++) push(mkrow(16'h100 + 4*r), 1);
    pat = 4'b1001;
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
      out_ready = pat[i % 4];
      tick;
    end
    out_ready = 1'b1;
    drain;
    chk("bp_words", hs_cnt - h0, 16);
    chk("bp_last_data", last_data, 16'h010F);

    // overflow: drain stalled on row A, then five rows back to back
    pulse_start;
    push(mkrow(16'h200), 1);
    repeat (3) tick;
    push(mkrow(16'h210), 1);
    push(mkrow(16'h220), 1);
    push(mkrow(16'h230), 1);
    chk("ovf_ready_before_4th", row_ready, 1);
    push(mkrow(16'h240), 1);
    chk("ovf_ready_full", row_ready, 0);
    chk("ovf_not_yet", overflow, 0);
    push(mkrow(16'h250), 0);
    chk("ovf_set", overflow, 1);
    chk("ovf_still_full", row_ready, 0);
    out_ready = 1'b1;
    drain;
    chk("ovf_sticky", overflow, 1);
    chk("ovf_last_data", last_data, 16'h0243);

    // full FIFO with simultaneous push and pop
    pulse_start;
    chk("start_clears_ovf", overflow, 0);
    push(mkrow(16'h300), 1);
    repeat (3) tick;
    for (int r = 1; r < 5; r++) push(mkrow(16'h300 + 16*r), 1);
    chk("fp_full", row_ready, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (!out_valid) break;
    end
    chk("fp_load_cycle", out_valid, 0);
    chk("fp_full_in_load", row_ready, 0);
    push(mkrow(16'h3F0), 0);
    chk("fp_count_dropped", row_ready, 1);
    chk("fp_overflow", overflow, 1);
    drain;

    // mid-tile start, with a row offered in the same cycle
    pulse_start;
    out_ready = 1'b1;
    h0 = hs_cnt;
    for (int r = 0; r < 4; r++) push(mkrow(16'h400 + 4*r), 1);
    for (int i = 0; i < 100 && (hs_cnt - h0) < 6; i++) tick;
    chk("mid_words_before_start", hs_cnt - h0, 6);
    out_ready = 1'b0;
    start = 1'b1;
    in_valid_C = 1'b1;
    row_in = mkrow(16'h4F0);
    tick;
    start = 1'b0;
    in_valid_C = 1'b0;
    chk("mid_valid_off", out_valid, 0);
    chk("mid_ready", row_ready, 1);
    chk("mid_ovf", overflow, 0);
    repeat (4) tick;
    chk("mid_fifo_empty", out_valid, 0);
    chk("mid_ovf_later", overflow, 0);
    out_ready = 1'b1;
    h0 = hs_cnt;
    for (int r = 0; r < 4; r++) push(mkrow(16'h500 + 4*r), 1);
    drain;
    chk("new_tile_words", hs_cnt - h0, 16);
    chk("new_tile_last", last_last, 1);
    chk("new_tile_last_data", last_data, 16'h050F);

    // randomized traffic, pushes only offered while the FIFO has room
    pulse_start;
    for (int i = 0; i < 500; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (row_ready && $urandom_range(0, 2) == 0) push({$urandom, $urandom}, 1);
      else tick;
    end
    out_ready = 1'b1;
    drain;
    chk("rand_no_overflow", overflow, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
